// File: rtl/a51_pkg.sv
// ============================================================================
// Module  : a51_pkg
// Purpose : Shared A5/1 register geometry, stage lengths and FSM encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package a51_pkg;

    localparam int R1_LEN = 19;
    localparam int R2_LEN = 22;
    localparam int R3_LEN = 23;

    localparam int R1_CLK = 8;
    localparam int R2_CLK = 10;
    localparam int R3_CLK = 10;

    // Feedback masks: R1 {18,17,16,13}, R2 {21,20}, R3 {22,21,20,7}
    localparam logic [R1_LEN-1:0] R1_TAPS = 19'h7_2000;
    localparam logic [R2_LEN-1:0] R2_TAPS = 22'h30_0000;
    localparam logic [R3_LEN-1:0] R3_TAPS = 23'h70_0080;

    localparam int KEY_CYCLES   = 64;
    localparam int FRAME_CYCLES = 22;
    localparam int MIX_CYCLES   = 100;
    localparam int GEN_CYCLES   = 8;
    localparam int STEP_CNT_W   = 7;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_KEY   = 3'd1,
        LOAD_FRAME = 3'd2,
        MIX        = 3'd3,
        GEN        = 3'd4,
        XFER       = 3'd5,
        DRAIN      = 3'd6
    } a51_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

`default_nettype wire

// File: rtl/a51_core.sv
// ============================================================================
// Module  : a51_core
// Purpose : A5/1 register bank (R1-R3) with load and majority-clocked stepping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module a51_core
    import a51_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic step_en_i,
    input  logic load_mode_i,
    input  logic load_bit_i,
    output logic ks_bit_o
);

    logic [R1_LEN-1:0] r1_q, r1_d;
    logic [R2_LEN-1:0] r2_q, r2_d;
    logic [R3_LEN-1:0] r3_q, r3_d;

    logic w_inj;
    logic w_fb1, w_fb2, w_fb3;
    logic w_maj;
    logic w_en1, w_en2, w_en3;

    assign w_inj = load_mode_i & load_bit_i;
    assign w_fb1 = (^(r1_q & R1_TAPS)) ^ w_inj;
    assign w_fb2 = (^(r2_q & R2_TAPS)) ^ w_inj;
    assign w_fb3 = (^(r3_q & R3_TAPS)) ^ w_inj;

    // Loading steps every register; otherwise only those agreeing with majority
    assign w_maj = maj3(r1_q[R1_CLK], r2_q[R2_CLK], r3_q[R3_CLK]);
    assign w_en1 = load_mode_i || (r1_q[R1_CLK] == w_maj);
    assign w_en2 = load_mode_i || (r2_q[R2_CLK] == w_maj);
    assign w_en3 = load_mode_i || (r3_q[R3_CLK] == w_maj);

    always_comb begin
        r1_d = r1_q;
        r2_d = r2_q;
        r3_d = r3_q;
        if (clear_i) begin
            r1_d = '0;
            r2_d = '0;
            r3_d = '0;
        end else if (step_en_i) begin
            if (w_en1) r1_d = {r1_q[R1_LEN-2:0], w_fb1};
            if (w_en2) r2_d = {r2_q[R2_LEN-2:0], w_fb2};
            if (w_en3) r3_d = {r3_q[R3_LEN-2:0], w_fb3};
        end
    end

    // Keystream bit is taken from the post-step register values
    assign ks_bit_o = r1_d[R1_LEN-1] ^ r2_d[R2_LEN-1] ^ r3_d[R3_LEN-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1_q <= '0;
            r2_q <= '0;
            r3_q <= '0;
        end else begin
            r1_q <= r1_d;
            r2_q <= r2_d;
            r3_q <= r3_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/a51_stream_decrypt.sv
// ============================================================================
// Module  : a51_stream_decrypt
// Purpose : A5/1 setup sequencer and byte-wise ciphertext-to-plaintext stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module a51_stream_decrypt
    import a51_pkg::*;
#(
    parameter int MSG_BYTES = 16,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [63:0]      key,
    input  logic [21:0]      frame,
    input  logic             start,
    output logic             busy,
    output logic             setup_done,
    input  logic             ct_valid,
    input  logic [7:0]       ct_data,
    output logic             ct_ready,
    output logic             pt_valid,
    output logic [7:0]       pt_data,
    input  logic             pt_ready,
    output logic [CNT_W-1:0] byte_count,
    output logic             done
);

    a51_state_e             state_q, state_d;
    logic [STEP_CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]       byte_cnt_q, byte_cnt_d;
    logic [7:0]             ks_q, ks_d;
    logic                   pt_valid_q, pt_valid_d;
    logic [7:0]             pt_data_q, pt_data_d;
    logic                   done_q, done_d;

    logic w_core_clear;
    logic w_core_step;
    logic w_core_load;
    logic w_core_bit;
    logic w_ks_bit;
    logic w_ct_ready;
    logic w_ct_hs;

    a51_core u_core (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (w_core_clear),
        .step_en_i   (w_core_step),
        .load_mode_i (w_core_load),
        .load_bit_i  (w_core_bit),
        .ks_bit_o    (w_ks_bit)
    );

    assign w_ct_ready = (state_q == XFER) && (!pt_valid_q || pt_ready);
    assign w_ct_hs    = w_ct_ready && ct_valid;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        byte_cnt_d   = byte_cnt_q;
        ks_d         = ks_q;
        pt_valid_d   = pt_valid_q;
        pt_data_d    = pt_data_q;
        done_d       = 1'b0;
        w_core_clear = 1'b0;
        w_core_step  = 1'b0;
        w_core_load  = 1'b0;
        w_core_bit   = 1'b0;

        if (pt_ready) pt_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = LOAD_KEY;
                    cnt_d        = '0;
                    byte_cnt_d   = '0;
                    w_core_clear = 1'b1;
                end
            end
            LOAD_KEY: begin
                w_core_step = 1'b1;
                w_core_load = 1'b1;
                w_core_bit  = key[cnt_q[5:0]];
                cnt_d       = cnt_q + 7'd1;
                if (cnt_q == STEP_CNT_W'(KEY_CYCLES - 1)) begin
                    state_d = LOAD_FRAME;
                    cnt_d   = '0;
                end
            end
            LOAD_FRAME: begin
                w_core_step = 1'b1;
                w_core_load = 1'b1;
                w_core_bit  = frame[cnt_q[4:0]];
                cnt_d       = cnt_q + 7'd1;
                if (cnt_q == STEP_CNT_W'(FRAME_CYCLES - 1)) begin
                    state_d = MIX;
                    cnt_d   = '0;
                end
            end
            MIX: begin
                w_core_step = 1'b1;
                cnt_d       = cnt_q + 7'd1;
                if (cnt_q == STEP_CNT_W'(MIX_CYCLES - 1)) begin
                    state_d = GEN;
                    cnt_d   = '0;
                end
            end
            GEN: begin
                w_core_step = 1'b1;
                ks_d        = {ks_q[6:0], w_ks_bit};
                cnt_d       = cnt_q + 7'd1;
                if (cnt_q == STEP_CNT_W'(GEN_CYCLES - 1)) begin
                    state_d = XFER;
                    cnt_d   = '0;
                end
            end
            XFER: begin
                if (w_ct_hs) begin
                    pt_data_d  = ct_data ^ ks_q;
                    pt_valid_d = 1'b1;
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    if (byte_cnt_q == CNT_W'(MSG_BYTES - 1)) begin
                        done_d  = 1'b1;
                        state_d = DRAIN;
                    end else begin
                        state_d = GEN;
                        cnt_d   = '0;
                    end
                end
            end
            DRAIN: begin
                if (!pt_valid_q || pt_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            byte_cnt_q <= '0;
            ks_q       <= '0;
            pt_valid_q <= 1'b0;
            pt_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_cnt_q <= byte_cnt_d;
            ks_q       <= ks_d;
            pt_valid_q <= pt_valid_d;
            pt_data_q  <= pt_data_d;
            done_q     <= done_d;
        end
    end

    // done is registered, so it is seen together with the last pt_valid
    assign busy       = (state_q != IDLE);
    assign setup_done = (state_q == GEN) || (state_q == XFER) || (state_q == DRAIN);
    assign ct_ready   = w_ct_ready;
    assign pt_valid   = pt_valid_q;
    assign pt_data    = pt_data_q;
    assign byte_count = byte_cnt_q;
    assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_a51_stream_decrypt.sv
// ============================================================================
// Module  : tb_a51_stream_decrypt
// Purpose : Directed self-checking bench for a51_stream_decrypt.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_a51_stream_decrypt;

    localparam int MSG = 16;

    logic        clk;
    logic        reset;
    logic [63:0] key;
    logic [21:0] frame;
    logic        start;
    logic        busy;
    logic        setup_done;
    logic        ct_valid;
    logic [7:0]  ct_data;
    logic        ct_ready;
    logic        pt_valid;
    logic [7:0]  pt_data;
    logic        pt_ready;
    logic [4:0]  byte_count;
    logic        done;

    int checks;
    int errors;

    logic [7:0] ks_ref [MSG];
    logic [7:0] ct_buf [MSG];
    logic [7:0] pt_exp [MSG];
    logic [7:0] pt_buf [MSG];
    int         done_cnt;
    int         first_ready;
    int         first_setup;
    logic       last_busy;
    int         got_bytes;

    a51_stream_decrypt #(
        .MSG_BYTES (MSG),
        .CNT_W     (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key        (key),
        .frame      (frame),
        .start      (start),
        .busy       (busy),
        .setup_done (setup_done),
        .ct_valid   (ct_valid),
        .ct_data    (ct_data),
        .ct_ready   (ct_ready),
        .pt_valid   (pt_valid),
        .pt_data    (pt_data),
        .pt_ready   (pt_ready),
        .byte_count (byte_count),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model written C-style on 32-bit words
    function automatic logic [31:0] lfsr_step(input logic [31:0] r, input logic [31:0] mask,
                                              input logic [31:0] taps, input logic in_bit);
        logic fb;
        fb = (^(r & taps)) ^ in_bit;
        return ((r << 1) | {31'd0, fb}) & mask;
    endfunction

    task automatic model_keystream(input logic [63:0] k, input logic [21:0] f);
        logic [31:0] a, b, c;
        logic m1, m2, m3, mj, kb;
        logic [7:0] acc;
        a = '0; b = '0; c = '0;
        for (int i = 0; i < 64; i++) begin
            a = lfsr_step(a, 32'h0007_FFFF, 32'h0007_2000, k[i]);
            b = lfsr_step(b, 32'h003F_FFFF, 32'h0030_0000, k[i]);
            c = lfsr_step(c, 32'h007F_FFFF, 32'h0070_0080, k[i]);
        end
        for (int i = 0; i < 22; i++) begin
            a = lfsr_step(a, 32'h0007_FFFF, 32'h0007_2000, f[i]);
            b = lfsr_step(b, 32'h003F_FFFF, 32'h0030_0000, f[i]);
            c = lfsr_step(c, 32'h007F_FFFF, 32'h0070_0080, f[i]);
        end
        for (int i = 0; i < 100 + 8 * MSG; i++) begin
            m1 = a[8]; m2 = b[10]; m3 = c[10];
            mj = (m1 & m2) | (m1 & m3) | (m2 & m3);
            if (m1 == mj) a = lfsr_step(a, 32'h0007_FFFF, 32'h0007_2000, 1'b0);
            if (m2 == mj) b = lfsr_step(b, 32'h003F_FFFF, 32'h0030_0000, 1'b0);
            if (m3 == mj) c = lfsr_step(c, 32'h007F_FFFF, 32'h0070_0080, 1'b0);
            if (i >= 100) begin
                kb  = a[18] ^ b[21] ^ c[22];
                acc = (((i - 100) % 8) == 0) ? 8'd0 : ks_ref[(i - 100) / 8];
                ks_ref[(i - 100) / 8] = {acc[6:0], kb};
            end
        end
    endtask

    // Runs one session from IDLE; starts and ends on a falling edge
    task automatic run_session(input bit stall, input bit poke, input int abort_after);
        int in_idx;
        int cyc;
        int stall_left;
        bit stalled;
        in_idx = 0; cyc = 0; stall_left = 0; stalled = 0;
        got_bytes = 0; done_cnt = 0; first_ready = -1; first_setup = -1; last_busy = 1'b0;
        start = 1'b1; ct_valid = 1'b0; pt_ready = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (got_bytes < abort_after && cyc < 4000) begin
            start    = 1'b0;
            ct_valid = (in_idx < MSG);
            ct_data  = (in_idx < MSG) ? ct_buf[in_idx] : 8'h00;
            if (stall && !stalled && pt_valid) begin
                stalled    = 1;
                stall_left = 20;
            end
            pt_ready = (stall_left == 0);
            if (poke && cyc == 120) start = 1'b1;
            #1;
            if (ct_ready && first_ready < 0) first_ready = cyc;
            if (setup_done && first_setup < 0) first_setup = cyc;
            if (stall_left > 0) begin
                checks++;
                if (pt_data !== pt_exp[0]) begin
                    errors++;
                    $display("FAIL stall_pt_data cyc %0d: got %02h expected %02h", cyc, pt_data, pt_exp[0]);
                end
                checks++;
                if (ct_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_ct_ready cyc %0d: got %b expected 0", cyc, ct_ready);
                end
                stall_left--;
            end
            if (done) done_cnt++;
            if (poke && ct_ready && in_idx == 3) start = 1'b1;
            if (pt_valid && pt_ready) begin
                pt_buf[got_bytes] = pt_data;
                last_busy = busy;
                got_bytes++;
            end
            if (ct_valid && ct_ready) in_idx++;
            @(negedge clk);
            cyc++;
        end
        ct_valid = 1'b0;
        start    = 1'b0;
        if (cyc >= 4000) begin
            checks++;
            errors++;
            $display("FAIL session_timeout: got %0d bytes expected %0d", got_bytes, abort_after);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; ct_valid = 1'b0; ct_data = 8'h00;
        pt_ready = 1'b0; key = '0; frame = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy, setup_done, ct_ready, pt_valid, pt_data, byte_count, done} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {busy, setup_done, ct_ready, pt_valid, pt_data, byte_count, done});
        end
        reset = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_without_start busy: got %b expected 0", busy);
        end
        @(negedge clk);
    endtask

    task automatic test_setup_timing();
        key = 64'h0123_4567_89AB_CDEF; frame = 22'h134;
        model_keystream(key, frame);
        for (int i = 0; i < MSG; i++) begin
            ct_buf[i] = 8'h00;
            pt_exp[i] = ks_ref[i];
        end
        run_session(1'b0, 1'b0, MSG);
        checks++;
        if (first_ready !== 195) begin
            errors++;
            $display("FAIL first_ct_ready_cycle: got %0d expected 195", first_ready);
        end
        checks++;
        if (first_setup !== 187) begin
            errors++;
            $display("FAIL first_setup_done_cycle: got %0d expected 187", first_setup);
        end
    endtask

    task automatic test_known_answer();
        key = 64'h0123_4567_89AB_CDEF; frame = 22'h134;
        model_keystream(key, frame);
        for (int i = 0; i < MSG; i++) begin
            ct_buf[i] = 8'h00;
            pt_exp[i] = ks_ref[i];
        end
        run_session(1'b0, 1'b0, MSG);
        for (int i = 0; i < MSG; i++) begin
            checks++;
            if (pt_buf[i] !== pt_exp[i]) begin
                errors++;
                $display("FAIL kat_byte[%0d]: got %02h expected %02h", i, pt_buf[i], pt_exp[i]);
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL kat_done_pulses: got %0d expected 1", done_cnt);
        end
        #1;
        checks++;
        if (byte_count !== 5'd16) begin
            errors++;
            $display("FAIL kat_byte_count: got %0d expected 16", byte_count);
        end
        @(negedge clk);
    endtask

    task automatic test_round_trip();
        logic [127:0] msg;
        msg = "QWERTYUIOPASDFGH";
        key = 64'hFEDC_BA98_7654_3210; frame = 22'h2A_BCD;
        model_keystream(key, frame);
        for (int i = 0; i < MSG; i++) begin
            pt_exp[i] = msg[127 - 8 * i -: 8];
            ct_buf[i] = pt_exp[i] ^ ks_ref[i];
        end
        run_session(1'b0, 1'b0, MSG);
        for (int i = 0; i < MSG; i++) begin
            checks++;
            if (pt_buf[i] !== pt_exp[i]) begin
                errors++;
                $display("FAIL roundtrip_byte[%0d]: got %02h expected %02h", i, pt_buf[i], pt_exp[i]);
            end
        end
        #1;
        checks++;
        if (last_busy !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL roundtrip_busy_fall: got %b%b expected 10", last_busy, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        key = 64'h0123_4567_89AB_CDEF; frame = 22'h134;
        model_keystream(key, frame);
        for (int i = 0; i < MSG; i++) begin
            ct_buf[i] = 8'h5A ^ 8'(i);
            pt_exp[i] = ct_buf[i] ^ ks_ref[i];
        end
        run_session(1'b1, 1'b0, MSG);
        for (int i = 0; i < MSG; i++) begin
            checks++;
            if (pt_buf[i] !== pt_exp[i]) begin
                errors++;
                $display("FAIL backpressure_byte[%0d]: got %02h expected %02h", i, pt_buf[i], pt_exp[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_start_misuse();
        key = 64'h0F1E_2D3C_4B5A_6978; frame = 22'h01_5555;
        model_keystream(key, frame);
        for (int i = 0; i < MSG; i++) begin
            ct_buf[i] = 8'(8'hC3 + 8'(i * 7));
            pt_exp[i] = ct_buf[i] ^ ks_ref[i];
        end
        run_session(1'b0, 1'b1, MSG);
        for (int i = 0; i < MSG; i++) begin
            checks++;
            if (pt_buf[i] !== pt_exp[i]) begin
                errors++;
                $display("FAIL misuse_byte[%0d]: got %02h expected %02h", i, pt_buf[i], pt_exp[i]);
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL misuse_done_pulses: got %0d expected 1", done_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        key = 64'h0123_4567_89AB_CDEF; frame = 22'h134;
        model_keystream(key, frame);
        for (int i = 0; i < MSG; i++) begin
            ct_buf[i] = 8'h00;
            pt_exp[i] = ks_ref[i];
        end
        run_session(1'b0, 1'b0, 5);
        ct_valid = 1'b1;
        #1;
        checks++;
        if (byte_count !== 5'd5 || setup_done !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre_state: got count %0d setup %b expected 5 1", byte_count, setup_done);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({busy, setup_done, ct_ready, pt_valid, pt_data, byte_count, done} !== 18'd0) begin
            errors++;
            $display("FAIL abort_async_outputs: got %h expected 0",
                     {busy, setup_done, ct_ready, pt_valid, pt_data, byte_count, done});
        end
        @(negedge clk);
        reset = 1'b0;
        ct_valid = 1'b0;
        @(negedge clk);
        run_session(1'b0, 1'b0, MSG);
        for (int i = 0; i < MSG; i++) begin
            checks++;
            if (pt_buf[i] !== pt_exp[i]) begin
                errors++;
                $display("FAIL abort_restart_byte[%0d]: got %02h expected %02h", i, pt_buf[i], pt_exp[i]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_setup_timing();
        test_known_answer();
        test_round_trip();
        test_backpressure();
        test_start_misuse();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
